divider_sequential: RTL

Iterative unsigned divider, the inverse of the team's 32x32->64 parallel multiplier: divides a 64-bit dividend by a 32-bit divisor into a 32-bit quotient and a 32-bit remainder. It resolves one quotient bit per cycle using restoring division. It sits beside the multiplier in the functional-unit set and uses the same valid_in/valid_out pulse style, plus a ready output because it is multi-cycle.

---
 rtl/divider_pkg.sv | 30 +++
 rtl/divider_step.sv | 18 +
 rtl/divider_sequential.sv | 125 ++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] ERR_QUOT  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        div_zero;
    logic        overflow;
  } div_rsp_t;

  // Overflow is only meaningful for a non-zero divisor; div_zero wins otherwise.
  function automatic logic div_ovf(input logic [31:0] a_hi, input logic [31:0] b);
    return (b != 32'd0) && (a_hi >= b);
  endfunction

  function automatic div_rsp_t div_err_rsp(input logic dz, input logic [31:0] a_lo);
    div_rsp_t rsp;
    rsp.q        = ERR_QUOT;
    rsp.r        = a_lo;
    rsp.div_zero = dz;
    rsp.overflow = !dz;
    return rsp;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module divider_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] rem_sh;

  always_comb begin
    rem_sh  = {rem_in, dvd_bit};
    q_bit   = (rem_sh >= {2'b00, divisor});
    rem_out = 33'(q_bit ? (rem_sh - {2'b00, divisor}) : rem_sh);
  end

endmodule

// File: rtl/divider_sequential.sv
// 64/32 iterative unsigned divider, one quotient bit per cycle.
// DIVIDER_FAST_ERR_EN: skip the iteration when div_zero/overflow is known at accept.
module divider_sequential
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [63:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        valid_out,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div_zero,
  output logic        overflow
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;    // dividend bits out of the top, quotient bits in at the bottom
  logic [31:0] div_q, div_d;
  logic [31:0] alo_q, alo_d;    // kept for the forced remainder on error
  logic        dz_q, dz_d;
  logic        ov_q, ov_d;
  div_rsp_t    rsp_q, rsp_d;
  logic        valid_out_q, valid_out_d;

  logic [32:0] step_rem;
  logic        step_qbit;
  logic        accept;

  divider_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[31]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign accept = valid_in && ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    div_d       = div_q;
    alo_d       = alo_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    rsp_d       = rsp_q;
    valid_out_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          dvd_d   = a[31:0];
          alo_d   = a[31:0];
          div_d   = b;
          rem_d   = {1'b0, a[63:32]};
          dz_d    = (b == 32'd0);
          ov_d    = div_ovf(a[63:32], b);
          cnt_d   = 5'd0;
          state_d = CALC;
`ifdef DIVIDER_FAST_ERR_EN
          if (dz_d || ov_d) begin
            state_d     = DONE;
            valid_out_d = 1'b1;
            rsp_d       = div_err_rsp(dz_d, a[31:0]);
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[30:0], step_qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_STEPS - 1)) begin
          state_d     = DONE;
          valid_out_d = 1'b1;
          if (dz_q || ov_q) rsp_d = div_err_rsp(dz_q, alo_q);
          else              rsp_d = '{q: dvd_d, r: rem_d[31:0], div_zero: 1'b0, overflow: 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      alo_q       <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      rsp_q       <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      div_q       <= div_d;
      alo_q       <= alo_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      rsp_q       <= rsp_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign q         = rsp_q.q;
  assign r         = rsp_q.r;
  assign div_zero  = rsp_q.div_zero;
  assign overflow  = rsp_q.overflow;

endmodule
